// File: rtl/uart_tx_sched_if.sv
// Requester byte streams and the UART_DATA transmit port shared by uart_tx_sched.
// The scheduler connects through the slave modport; requesters and the UART connect through master.
interface uart_tx_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        uart_din;
  logic              uart_wr_en;
  logic              uart_tx_busy;

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, grant, uart_din, uart_wr_en
  );

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, grant, uart_din, uart_wr_en
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte streams.
// A granted requester keeps the UART until its last byte, with timeouts on every wait.
module uart_tx_sched #(
  parameter int NREQ    = 4,
  parameter int BUSY_TO = 8,
  parameter int LOCK_TO = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_sched_if.slave  bus,
  output logic            sched_busy,
  output logic            busy_timeout,
  output logic            lock_drop
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(BUSY_TO + 1);
  localparam int LW = $clog2(LOCK_TO + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;

  logic [2:0]      state_r, state_n;
  logic [PW-1:0]   ptr_r, ptr_n;
  logic [PW-1:0]   owner_r, owner_n;
  logic [NREQ-1:0] grant_r, grant_n;
  logic [NREQ-1:0] ready_r, ready_n;
  logic [7:0]      din_r, din_n;
  logic            last_r, last_n;
  logic            wr_en_r, wr_en_n;
  logic [BW-1:0]   bcnt_r, bcnt_n;
  logic [LW-1:0]   lcnt_r, lcnt_n;
  logic            bto_r, bto_n;
  logic            ldrop_r, ldrop_n;
  logic            sched_busy_r;

  logic            pick_found_s;
  logic [PW-1:0]   pick_idx_s;
  logic [PW-1:0]   cand_s;
  logic [NREQ-1:0] pick_oh_s;
  logic            xfer_s;
  logic [7:0]      owner_data_s;
  logic            owner_last_s;
  logic            bto_hit_s;
  logic            done_s;
  logic [BW-1:0]   bcnt_inc_s;
  logic [LW-1:0]   lcnt_inc_s;

  assign owner_data_s = bus.req_data[{owner_r, 3'b000} +: 8];
  assign owner_last_s = bus.req_last[owner_r];
  assign xfer_s       = bus.req_valid[owner_r] & ready_r[owner_r];
  assign pick_oh_s    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;

  // Counters saturate at their limit instead of wrapping.
  assign bcnt_inc_s = (bcnt_r == BW'(BUSY_TO)) ? bcnt_r : bcnt_r + BW'(1);
  assign lcnt_inc_s = (lcnt_r == LW'(LOCK_TO)) ? lcnt_r : lcnt_r + LW'(1);

  // The decision is taken one cycle early so the registered pulse lands BUSY_TO cycles after wr_en.
  assign bto_hit_s = (state_r == S_WAIT_HI) && !bus.uart_tx_busy && (bcnt_r == BW'(BUSY_TO - 2));
  assign done_s    = bto_hit_s || ((state_r == S_WAIT_LO) && !bus.uart_tx_busy);

  // Round-robin pick: first valid requester searching ptr+1, ptr+2, ... modulo NREQ.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = PW'((int'(ptr_r) + i) % NREQ);
      if (!pick_found_s && bus.req_valid[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    owner_n = owner_r;
    grant_n = grant_r;
    ready_n = '0;
    din_n   = din_r;
    last_n  = last_r;
    wr_en_n = 1'b0;
    bcnt_n  = bcnt_r;
    lcnt_n  = lcnt_r;
    bto_n   = 1'b0;
    ldrop_n = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pick_found_s) begin
          owner_n = pick_idx_s;
          grant_n = pick_oh_s;
          ready_n = pick_oh_s;
          lcnt_n  = '0;
          state_n = S_FETCH;
        end else begin
          grant_n = '0;
        end
      end
      S_FETCH: begin
        if (xfer_s) begin
          din_n   = owner_data_s;
          last_n  = owner_last_s;
          wr_en_n = 1'b1;
          state_n = S_LOAD;
        end else if (lcnt_r == LW'(LOCK_TO - 1)) begin
          ldrop_n = 1'b1;
          ptr_n   = owner_r;
          grant_n = '0;
          state_n = S_IDLE;
        end else begin
          ready_n = grant_r;
          lcnt_n  = lcnt_inc_s;
        end
      end
      S_LOAD: begin
        bcnt_n  = '0;
        state_n = S_WAIT_HI;
      end
      S_WAIT_HI, S_WAIT_LO: begin
        bto_n = bto_hit_s;
        if (done_s && last_r) begin
          ptr_n   = owner_r;
          grant_n = '0;
          state_n = S_IDLE;
        end else if (done_s) begin
          ready_n = grant_r;
          lcnt_n  = '0;
          state_n = S_FETCH;
        end else if (bus.uart_tx_busy) begin
          state_n = S_WAIT_LO;
        end else begin
          bcnt_n = bcnt_inc_s;
        end
      end
      default: begin
        grant_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      ptr_r        <= PW'(NREQ - 1);
      owner_r      <= '0;
      grant_r      <= '0;
      ready_r      <= '0;
      din_r        <= 8'h00;
      last_r       <= 1'b0;
      wr_en_r      <= 1'b0;
      bcnt_r       <= '0;
      lcnt_r       <= '0;
      bto_r        <= 1'b0;
      ldrop_r      <= 1'b0;
      sched_busy_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      ptr_r        <= ptr_n;
      owner_r      <= owner_n;
      grant_r      <= grant_n;
      ready_r      <= ready_n;
      din_r        <= din_n;
      last_r       <= last_n;
      wr_en_r      <= wr_en_n;
      bcnt_r       <= bcnt_n;
      lcnt_r       <= lcnt_n;
      bto_r        <= bto_n;
      ldrop_r      <= ldrop_n;
      sched_busy_r <= (state_n != S_IDLE);
    end
  end

  assign bus.req_ready  = ready_r;
  assign bus.grant      = grant_r;
  assign bus.uart_din   = din_r;
  assign bus.uart_wr_en = wr_en_r;
  assign sched_busy     = sched_busy_r;
  assign busy_timeout   = bto_r;
  assign lock_drop      = ldrop_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester queues, a UART busy model and immediate-assert checks.
module tb_uart_tx_sched;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sched_busy;
  logic busy_timeout;
  logic lock_drop;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  uart_tx_sched_if #(.NREQ(NREQ)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .BUSY_TO(8), .LOCK_TO(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sched_busy   (sched_busy),
    .busy_timeout (busy_timeout),
    .lock_drop    (lock_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]      qmem [NREQ][16];
  int              qhead [NREQ];
  int              qtail [NREQ];
  logic            flush = 1'b0;
  logic            uart_mode = 1'b0;
  logic [NREQ-1:0] prev_ready = '0;
  int              wr_n = 0;
  logic [7:0]      wr_data [64];
  int              wr_cyc [64];
  int              bto_n = 0;
  int              bto_cyc [16];
  int              ld_n = 0;
  int              ld_cyc [16];
  logic [NREQ-1:0] ld_grant = '0;
  int              busy_cnt = 0;
  int              drop_cyc = 0;

  // Environment: requester queues, event logs and the UART busy model, all updated on the falling edge.
  initial begin
    logic [8:0] ent;
    for (int i = 0; i < NREQ; i++) begin
      qhead[i] = 0;
      qtail[i] = 0;
    end
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.req_last     = '0;
    bus.uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && prev_ready[i]) qhead[i] = qhead[i] + 1;
      if (flush) begin
        for (int i = 0; i < NREQ; i++) qhead[i] = qtail[i];
        flush = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (qhead[i] != qtail[i]) begin
          ent = qmem[i][qhead[i]];
          bus.req_valid[i]      = 1'b1;
          bus.req_data[8*i +: 8] = ent[7:0];
          bus.req_last[i]       = ent[8];
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]       = 1'b0;
        end
      end
      prev_ready = bus.req_ready;
      if (bus.uart_wr_en && wr_n < 64) begin
        wr_data[wr_n] = bus.uart_din;
        wr_cyc[wr_n]  = cyc;
        wr_n = wr_n + 1;
      end
      if (busy_timeout && bto_n < 16) begin
        bto_cyc[bto_n] = cyc;
        bto_n = bto_n + 1;
      end
      if (lock_drop && ld_n < 16) begin
        ld_cyc[ld_n] = cyc;
        ld_grant = bus.grant;
        ld_n = ld_n + 1;
      end
      if (bus.uart_tx_busy) begin
        busy_cnt = busy_cnt - 1;
        if (busy_cnt == 0) begin
          bus.uart_tx_busy = 1'b0;
          drop_cyc = cyc;
        end
      end else if (bus.uart_wr_en && !uart_mode) begin
        bus.uart_tx_busy = 1'b1;
        busy_cnt = 10;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    qmem[r][qtail[r]] = {last, d};
    qtail[r] = qtail[r] + 1;
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n = 0;
    while (wr_n < target && n < 500) begin
      step(1);
      n++;
    end
    check(tag, 32'(wr_n >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (sched_busy !== 1'b0 && n < 500) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, sched_busy}, 32'd0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: observed no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w0;
    int w1;
    int b0;
    int l0;

    // Reset values.
    rst_n = 1'b0;
    step(3);
    check("rst_grant", bus.grant, 32'd0);
    check("rst_ready", bus.req_ready, 32'd0);
    check("rst_din", bus.uart_din, 32'd0);
    check("rst_wr_en", bus.uart_wr_en, 32'd0);
    check("rst_sched_busy", sched_busy, 32'd0);
    check("rst_busy_timeout", busy_timeout, 32'd0);
    check("rst_lock_drop", lock_drop, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Single byte from requester 2.
    w0 = wr_n;
    push(2, 1'b1, 8'h41);
    step(2);
    check("t1_grant", bus.grant, 32'h4);
    check("t1_ready", bus.req_ready, 32'h4);
    check("t1_sched_busy", sched_busy, 32'd1);
    step(1);
    check("t1_wr_en", bus.uart_wr_en, 32'd1);
    check("t1_din", bus.uart_din, 32'h41);
    check("t1_ready_off", bus.req_ready, 32'd0);
    wait_idle("t1_idle");
    check("t1_idle_after_busy_fall", cyc, drop_cyc + 1);
    check("t1_pulse_count", wr_n - w0, 32'd1);
    check("t1_din_held", bus.uart_din, 32'h41);
    check("t1_grant_idle", bus.grant, 32'd0);

    // Simultaneous single-byte packets from 0 and 1, two rounds.
    w0 = wr_n;
    push(0, 1'b1, 8'h30);
    push(1, 1'b1, 8'h31);
    step(2);
    check("t2_grant", bus.grant, 32'h1);
    check("t2_ready_owner_only", bus.req_ready, 32'h1);
    wait_wr(w0 + 2, "t2_r1_wr_seen");
    wait_idle("t2_r1_idle");
    check("t2_r1_first", wr_data[w0], 32'h30);
    check("t2_r1_second", wr_data[w0+1], 32'h31);
    push(0, 1'b1, 8'h30);
    push(1, 1'b1, 8'h31);
    wait_wr(w0 + 4, "t2_r2_wr_seen");
    wait_idle("t2_r2_idle");
    check("t2_r2_first", wr_data[w0+2], 32'h30);
    check("t2_r2_second", wr_data[w0+3], 32'h31);

    // Packet lock: "OK\n" from 3 while requester 0 waits.
    w0 = wr_n;
    push(3, 1'b0, 8'h4F);
    push(3, 1'b0, 8'h4B);
    push(3, 1'b1, 8'h0A);
    push(0, 1'b1, 8'h52);
    step(2);
    check("t3_grant", bus.grant, 32'h8);
    check("t3_ready", bus.req_ready, 32'h8);
    wait_wr(w0 + 4, "t3_wr_seen");
    wait_idle("t3_idle");
    check("t3_byte0", wr_data[w0], 32'h4F);
    check("t3_byte1", wr_data[w0+1], 32'h4B);
    check("t3_byte2", wr_data[w0+2], 32'h0A);
    check("t3_after_lock", wr_data[w0+3], 32'h52);
    check("t3_gap01", wr_cyc[w0+1] - wr_cyc[w0], 32'd12);
    check("t3_gap12", wr_cyc[w0+2] - wr_cyc[w0+1], 32'd12);

    // Busy timeout: UART never raises tx_busy.
    uart_mode = 1'b1;
    w0 = wr_n;
    b0 = bto_n;
    push(2, 1'b0, 8'hA1);
    push(2, 1'b1, 8'hA2);
    wait_wr(w0 + 2, "t4_wr_seen");
    wait_idle("t4_idle");
    check("t4_pulse_count", bto_n - b0, 32'd2);
    check("t4_latency0", bto_cyc[b0] - wr_cyc[w0], 32'd8);
    check("t4_latency1", bto_cyc[b0+1] - wr_cyc[w0+1], 32'd8);
    check("t4_wr_gap", wr_cyc[w0+1] - wr_cyc[w0], 32'd9);
    check("t4_byte0", wr_data[w0], 32'hA1);
    check("t4_byte1", wr_data[w0+1], 32'hA2);
    uart_mode = 1'b0;

    // Lock timeout: requester 1 stalls mid-packet, requester 2 pending.
    w0 = wr_n;
    l0 = ld_n;
    b0 = bto_n;
    push(1, 1'b0, 8'h55);
    push(2, 1'b1, 8'h66);
    wait_wr(w0 + 2, "t5_wr_seen");
    wait_idle("t5_idle");
    check("t5_drop_count", ld_n - l0, 32'd1);
    check("t5_drop_latency", ld_cyc[l0] - wr_cyc[w0], 32'd27);
    check("t5_grant_at_drop", ld_grant, 32'd0);
    check("t5_byte_stalled", wr_data[w0], 32'h55);
    check("t5_next_served", wr_data[w0+1], 32'h66);
    check("t5_no_busy_timeout", bto_n - b0, 32'd0);

    // Reset while the first byte of a packet is in WAIT_LO.
    w0 = wr_n;
    push(3, 1'b0, 8'h77);
    push(3, 1'b1, 8'h78);
    wait_wr(w0 + 1, "t6_wr_seen");
    step(3);
    check("t6_pre_busy", sched_busy, 32'd1);
    check("t6_pre_grant", bus.grant, 32'h8);
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", bus.grant, 32'd0);
    check("t6_rst_ready", bus.req_ready, 32'd0);
    check("t6_rst_din", bus.uart_din, 32'd0);
    check("t6_rst_wr_en", bus.uart_wr_en, 32'd0);
    check("t6_rst_sched_busy", sched_busy, 32'd0);
    check("t6_rst_pulses", {30'd0, busy_timeout, lock_drop}, 32'd0);
    flush = 1'b1;
    step(12);
    rst_n = 1'b1;
    step(2);
    w1 = wr_n;
    push(3, 1'b1, 8'h90);
    push(0, 1'b1, 8'h91);
    step(2);
    check("t6_first_grant", bus.grant, 32'h1);
    wait_wr(w1 + 2, "t6_wr_after");
    wait_idle("t6_idle");
    check("t6_first_byte", wr_data[w1], 32'h91);
    check("t6_second_byte", wr_data[w1+1], 32'h90);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
